// File: rtl/hsosc_pkg.sv
// Shared definitions for the high-speed oscillator power sequencer: state encodings and
// default cycle counts, also used by the status-register block and the bench.
package hsosc_pkg;

  typedef enum logic [2:0] {
    StOff    = 3'd0,
    StPwrup  = 3'd1,
    StSettle = 3'd2,
    StOn     = 3'd3,
    StDrain  = 3'd4,
    StCool   = 3'd5
  } hsosc_state_e;

  localparam int unsigned DefPuWaitCycles = 2;  // 200 us at 10 kHz
  localparam int unsigned DefSettleCycles = 1;
  localparam int unsigned DefDrainCycles  = 1;
  localparam int unsigned DefMinOffCycles = 2;

  function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/hsosc_pwr_seq_if.sv
// Request/status bundle between power-management logic and the oscillator sequencer.
interface hsosc_pwr_seq_if;
  logic       req;
  logic       osc_pu;
  logic       osc_en;
  logic       osc_ready;
  logic       busy;
  logic [2:0] state_o;

  modport master (
    output req,
    input  osc_pu, osc_en, osc_ready, busy, state_o
  );

  modport slave (
    input  req,
    output osc_pu, osc_en, osc_ready, busy, state_o
  );
endinterface

// File: rtl/hsosc_pwr_seq_sync_2ff.sv
// Two-flop synchronizer for a single level signal, async reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic ff1_q, ff2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;
endmodule

// File: rtl/hsosc_pwr_seq.sv
// Always-on sequencer ordering power-up, enable and ready of the high-speed oscillator,
// and the reverse on shutdown with a guaranteed minimum off time.
module hsosc_pwr_seq
  import hsosc_pkg::*;
#(
  parameter int unsigned PU_WAIT_CYCLES = DefPuWaitCycles,
  parameter int unsigned SETTLE_CYCLES  = DefSettleCycles,
  parameter int unsigned DRAIN_CYCLES   = DefDrainCycles,
  parameter int unsigned MIN_OFF_CYCLES = DefMinOffCycles,
  parameter bit          SYNC_REQ       = 1'b1
) (
  input logic           clk,
  input logic           rst,
  hsosc_pwr_seq_if.slave pwr
);

  localparam int unsigned MaxCycles =
      max_cycles(PU_WAIT_CYCLES, SETTLE_CYCLES, DRAIN_CYCLES, MIN_OFF_CYCLES);
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] LdPuWait = CntW'(PU_WAIT_CYCLES);
  localparam logic [CntW-1:0] LdSettle = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0] LdDrain  = CntW'(DRAIN_CYCLES);
  localparam logic [CntW-1:0] LdMinOff = CntW'(MIN_OFF_CYCLES);

  logic req_s;

  if (SYNC_REQ) begin : g_sync
    sync_2ff u_sync (
      .clk(clk),
      .rst(rst),
      .d  (pwr.req),
      .q  (req_s)
    );
  end else begin : g_nosync
    assign req_s = pwr.req;
  end

  hsosc_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            expired;
  logic            pu_q, en_q, rdy_q, busy_q;

  // The counter is loaded with N on entry and the state is left on the N-th edge after.
  assign expired = (cnt_q <= CntW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = expired ? cnt_q : cnt_q - CntW'(1);
    case (state_q)
      StOff: begin
        if (req_s) begin
          state_d = StPwrup;
          cnt_d   = LdPuWait;
        end
      end
      StPwrup: begin
        if (!req_s) begin
          state_d = StCool;
          cnt_d   = LdMinOff;
        end else if (expired) begin
          state_d = StSettle;
          cnt_d   = LdSettle;
        end
      end
      StSettle: begin
        if (!req_s) begin
          state_d = StDrain;
          cnt_d   = LdDrain;
        end else if (expired) begin
          state_d = StOn;
        end
      end
      StOn: begin
        if (!req_s) begin
          state_d = StDrain;
          cnt_d   = LdDrain;
        end
      end
      StDrain: begin
        if (expired) begin
          state_d = StCool;
          cnt_d   = LdMinOff;
        end
      end
      StCool: begin
        if (expired) begin
          state_d = req_s ? StPwrup : StOff;
          cnt_d   = LdPuWait;
        end
      end
      default: begin
        state_d = StCool;
        cnt_d   = LdMinOff;
      end
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StCool;
      cnt_q   <= LdMinOff;
      pu_q    <= 1'b0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pu_q    <= state_d inside {StPwrup, StSettle, StOn, StDrain};
      en_q    <= state_d inside {StSettle, StOn};
      rdy_q   <= (state_d == StOn);
      busy_q  <= state_d inside {StPwrup, StSettle, StDrain, StCool};
    end
  end

  assign pwr.osc_pu    = pu_q;
  assign pwr.osc_en    = en_q;
  assign pwr.osc_ready = rdy_q;
  assign pwr.busy      = busy_q;
  assign pwr.state_o   = state_q;

endmodule

// File: tb/tb_hsosc_pwr_seq.sv
// Bench for hsosc_pwr_seq: unsynchronized and synchronized instances share one request,
// each checked every cycle against an elapsed-time model plus directed literal pins.
module tb_hsosc_pwr_seq;
  import hsosc_pkg::*;

  localparam int unsigned PU = 4;
  localparam int unsigned ST = 2;
  localparam int unsigned DR = 3;
  localparam int unsigned MO = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hsosc_pwr_seq_if bus0 ();
  hsosc_pwr_seq_if bus1 ();
  assign bus0.req = req;
  assign bus1.req = req;

  hsosc_pwr_seq #(
    .PU_WAIT_CYCLES(PU), .SETTLE_CYCLES(ST), .DRAIN_CYCLES(DR), .MIN_OFF_CYCLES(MO),
    .SYNC_REQ(1'b0)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .pwr(bus0.slave)
  );

  hsosc_pwr_seq #(
    .PU_WAIT_CYCLES(PU), .SETTLE_CYCLES(ST), .DRAIN_CYCLES(DR), .MIN_OFF_CYCLES(MO),
    .SYNC_REQ(1'b1)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .pwr(bus1.slave)
  );

  // {state, osc_pu, osc_en, osc_ready, busy}
  logic [6:0] o0, o1;
  assign o0 = {bus0.state_o, bus0.osc_pu, bus0.osc_en, bus0.osc_ready, bus0.busy};
  assign o1 = {bus1.state_o, bus1.osc_pu, bus1.osc_en, bus1.osc_ready, bus1.busy};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a phase plus the number of edges spent in it; leave after the phase's duration.
  typedef struct {
    logic [2:0] st;
    int         age;
  } mdl_t;

  mdl_t m0, m1;
  logic h1, h2;  // two-edge request delay seen by the synchronized instance

  function automatic mdl_t step(input mdl_t m, input logic r);
    mdl_t n;
    int   el;
    el   = m.age + 1;
    n.st = m.st;
    case (m.st)
      StOff:    if (r) n.st = StPwrup;
      StPwrup:  if (!r) n.st = StCool; else if (el == int'(PU)) n.st = StSettle;
      StSettle: if (!r) n.st = StDrain; else if (el == int'(ST)) n.st = StOn;
      StOn:     if (!r) n.st = StDrain;
      StDrain:  if (el == int'(DR)) n.st = StCool;
      StCool:   if (el == int'(MO)) n.st = r ? StPwrup : StOff;
      default:  n.st = StCool;
    endcase
    n.age = (n.st != m.st) ? 0 : el;
    return n;
  endfunction

  function automatic logic [6:0] exp_out(input logic [2:0] s);
    return {s, s inside {StPwrup, StSettle, StOn, StDrain}, s inside {StSettle, StOn},
            s == StOn, s inside {StPwrup, StSettle, StDrain, StCool}};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= '{st: StCool, age: 0};
      m1 <= '{st: StCool, age: 0};
      h1 <= 1'b0;
      h2 <= 1'b0;
    end else begin
      m0 <= step(m0, req);
      m1 <= step(m1, h2);
      h2 <= h1;
      h1 <= req;
    end
  end

  int   low_cnt[2]  = '{0, 0};
  int   wait_cnt[2] = '{0, 0};
  logic prev_pu[2]  = '{1'b0, 1'b0};
  logic prev_en[2]  = '{1'b0, 1'b0};

  task automatic inv(input int k, input logic pu, input logic en, input logic rdy);
    check($sformatf("dut%0d en_implies_pu", k), 32'(en && !pu), 32'd0);
    check($sformatf("dut%0d ready_implies_en", k), 32'(rdy && !en), 32'd0);
    if (pu && !prev_pu[k]) check($sformatf("dut%0d min_off", k), 32'(low_cnt[k] >= int'(MO)), 32'd1);
    if (en && !prev_en[k]) check($sformatf("dut%0d pu_wait", k), 32'(wait_cnt[k] >= int'(PU)), 32'd1);
    low_cnt[k]  = pu ? 0 : low_cnt[k] + 1;
    wait_cnt[k] = (pu && !en) ? wait_cnt[k] + 1 : 0;
    prev_pu[k]  = pu;
    prev_en[k]  = en;
  endtask

  always @(negedge clk) begin
    check("dut0 vs model", 32'(o0), 32'(exp_out(m0.st)));
    check("dut1 vs model", 32'(o1), 32'(exp_out(m1.st)));
    inv(0, bus0.osc_pu, bus0.osc_en, bus0.osc_ready);
    inv(1, bus1.osc_pu, bus1.osc_en, bus1.osc_ready);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pin(input string name, input logic [6:0] exp);
    check(name, 32'(o0), 32'(exp));
  endtask

  task automatic pin1(input string name, input logic [6:0] exp);
    check(name, 32'(o1), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b1;
    repeat (2) tick();
    pin("reset", {3'd5, 4'b0001});
    pin1("reset sync", {3'd5, 4'b0001});
    rst = 1'b0;

    // Power-up from reset with req held high.
    tick(); pin("cool e1", {3'd5, 4'b0001});
    tick(); pin("cool e2", {3'd5, 4'b0001});
    tick(); pin("pwrup entry", {3'd1, 4'b1001});
    for (int i = 0; i < 3; i++) begin
      tick(); pin("pwrup hold", {3'd1, 4'b1001});
    end
    tick(); pin("settle entry", {3'd2, 4'b1101});
    tick(); pin("settle hold", {3'd2, 4'b1101});
    tick(); pin("on entry", {3'd3, 4'b1110});

    // Shutdown from ON; the synchronized instance lags by two edges.
    req = 1'b0;
    tick(); pin("drain entry", {3'd4, 4'b1001}); pin1("sync still on 1", {3'd3, 4'b1110});
    tick(); pin("drain 2", {3'd4, 4'b1001});     pin1("sync still on 2", {3'd3, 4'b1110});
    tick(); pin("drain 3", {3'd4, 4'b1001});     pin1("sync drain entry", {3'd4, 4'b1001});
    tick(); pin("cool after drain", {3'd5, 4'b0001});
    tick(); tick(); pin("cool hold", {3'd5, 4'b0001});
    tick(); pin("off", {3'd0, 4'b0000});

    // Abort during PWRUP.
    req = 1'b1;
    tick(); pin("abort pwrup entry", {3'd1, 4'b1001});
    tick(); pin("abort pwrup e1", {3'd1, 4'b1001});
    req = 1'b0;
    tick(); pin("abort to cool", {3'd5, 4'b0001});
    tick(); tick(); pin("abort cool hold", {3'd5, 4'b0001});
    tick(); pin("abort off", {3'd0, 4'b0000});

    // Re-request during DRAIN and COOL.
    req = 1'b1;
    repeat (7) tick();
    pin("on again", {3'd3, 4'b1110});
    req = 1'b0;
    tick(); pin("rereq drain entry", {3'd4, 4'b1001});
    req = 1'b1;
    tick(); tick(); pin("rereq drain ignores req", {3'd4, 4'b1001});
    tick(); pin("rereq cool entry", {3'd5, 4'b0001});
    tick(); tick(); pin("rereq cool ignores req", {3'd5, 4'b0001});
    tick(); pin("cool to pwrup direct", {3'd1, 4'b1001});
    repeat (4) tick();
    pin("rereq settle", {3'd2, 4'b1101});
    tick(); tick(); pin("rereq on", {3'd3, 4'b1110});

    // Asynchronous reset between edges while ON.
    #1 rst = 1'b1;
    #1 pin("async reset", {3'd5, 4'b0001});
    pin1("async reset sync", {3'd5, 4'b0001});
    @(posedge clk);
    #2 rst = 1'b0;
    tick(); pin("post reset e1", {3'd5, 4'b0001});
    tick(); pin("post reset e2", {3'd5, 4'b0001});
    tick(); pin("post reset pwrup", {3'd1, 4'b1001}); pin1("post reset pwrup sync", {3'd1, 4'b1001});

    // Random request toggling; the per-cycle model and invariant checks cover it.
    for (int i = 0; i < 300; i++) begin
      req = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 9)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
